// File: rtl/count_display_mux.sv
// rtl/count_display_mux.sv - two-digit 7-segment multiplexer with counter wrap detection
module count_display_mux #(
    parameter logic [15:0] REFRESH_DIV  = 16'd50000,
    parameter logic [7:0]  BLANK_CYCLES = 8'd16,
    parameter int          WRAP_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        up_count,
    input  logic [3:0]        down_count,
    output logic [6:0]        seg,
    output logic [1:0]        an,
    output logic              up_wrap,
    output logic              down_wrap,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] down_wraps
);

    localparam logic [WRAP_W-1:0] TALLY_MAX = {WRAP_W{1'b1}};
    localparam logic [15:0]       DIV_LAST  = REFRESH_DIV - 16'd1;
    localparam logic [15:0]       BLANK_END = {8'd0, BLANK_CYCLES};

    logic [3:0]        up_q, up_d;
    logic [3:0]        down_q, down_d;
    logic              armed_q, armed_d;
    logic [15:0]       div_cnt_q, div_cnt_d;
    logic              digit_sel_q, digit_sel_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        an_q, an_d;
    logic              up_wrap_q, up_wrap_d;
    logic              down_wrap_q, down_wrap_d;
    logic [WRAP_W-1:0] up_wraps_q, up_wraps_d;
    logic [WRAP_W-1:0] down_wraps_q, down_wraps_d;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: capture, wrap detection, saturating tallies, refresh timing, display drive
    always_comb begin
        up_d     = up_count;
        down_d   = down_count;
        armed_d  = 1'b1;

        // armed_q keeps the zeroed capture registers from faking a wrap right after reset
        up_wrap_d   = armed_q && (up_q == 4'hF) && (up_count == 4'h0);
        down_wrap_d = armed_q && (down_q == 4'h0) && (down_count == 4'hF);

        up_wraps_d = up_wraps_q;
        if (up_wrap_q && (up_wraps_q != TALLY_MAX)) begin
            up_wraps_d = up_wraps_q + 1'b1;
        end
        down_wraps_d = down_wraps_q;
        if (down_wrap_q && (down_wraps_q != TALLY_MAX)) begin
            down_wraps_d = down_wraps_q + 1'b1;
        end

        div_cnt_d   = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
        digit_sel_d = digit_sel_q ^ (div_cnt_q == DIV_LAST);

        // Anode pattern is one-hot-low or all-off, never both digits on
        if (div_cnt_q < BLANK_END) begin
            an_d = 2'b11;
        end else if (digit_sel_q) begin
            an_d = 2'b01;
        end else begin
            an_d = 2'b10;
        end
        seg_d = hex7(digit_sel_q ? down_q : up_q);
    end

    // State register with synchronous reset; reset blanks the display at once
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q         <= 4'h0;
            down_q       <= 4'h0;
            armed_q      <= 1'b0;
            div_cnt_q    <= 16'd0;
            digit_sel_q  <= 1'b0;
            seg_q        <= 7'h7F;
            an_q         <= 2'b11;
            up_wrap_q    <= 1'b0;
            down_wrap_q  <= 1'b0;
            up_wraps_q   <= '0;
            down_wraps_q <= '0;
        end else begin
            up_q         <= up_d;
            down_q       <= down_d;
            armed_q      <= armed_d;
            div_cnt_q    <= div_cnt_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            up_wrap_q    <= up_wrap_d;
            down_wrap_q  <= down_wrap_d;
            up_wraps_q   <= up_wraps_d;
            down_wraps_q <= down_wraps_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign up_wrap    = up_wrap_q;
    assign down_wrap  = down_wrap_q;
    assign up_wraps   = up_wraps_q;
    assign down_wraps = down_wraps_q;

endmodule
